// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Two-state (FETCH/EXEC) program-counter sequencer. It accepts one
//            decoded instruction per FETCH cycle and resolves branches, output
//            toggles and multi-hot strobe errors in the following EXEC cycle.
// Ports    :
//   clk, rst            - clock; synchronous active-high reset
//   instr_valid/ready   - instruction handshake (ready only in FETCH)
//   bcf, bbf, buc       - branch-on-carry / -borrow / unconditional strobes
//   toggleOut           - invert the output-pin source select
//   carry, borrow       - ALU flags sampled with the instruction
//   r3                  - branch offset; also drives pins when out_sel = 0
//   load_en, load_val   - external PC load (FETCH only, beats instructions)
//   pc                  - program counter
//   out_sel             - 0: pins show r3, 1: pins show pc
//   io_out              - output-pin value (combinational)
//   branch_taken        - one-cycle pulse after a taken branch
//   err                 - sticky multi-hot strobe error
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       bcf,
  input  logic       bbf,
  input  logic       buc,
  input  logic       toggleOut,
  input  logic       carry,
  input  logic       borrow,
  input  logic [7:0] r3,
  input  logic       load_en,
  input  logic [7:0] load_val,
  output logic [7:0] pc,
  output logic       out_sel,
  output logic [7:0] io_out,
  output logic       branch_taken,
  output logic       err
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pc_nxt;
  logic       out_sel_nxt;
  logic       branch_taken_nxt;
  logic       err_nxt;
  logic       capture;

  // Instruction fields held for the EXEC cycle so live inputs can change.
  logic       cap_bcf;
  logic       cap_bbf;
  logic       cap_buc;
  logic       cap_tog;
  logic       cap_carry;
  logic       cap_borrow;
  logic [7:0] cap_r3;

  logic [2:0] strobe_cnt;
  logic       multi_hot;
  logic       take;

  // A pending load blocks acceptance for that cycle.
  assign instr_ready = (state == FETCH) && !load_en && !rst;

  assign strobe_cnt = {2'b00, cap_bcf} + {2'b00, cap_bbf}
                    + {2'b00, cap_buc} + {2'b00, cap_tog};
  assign multi_hot  = (strobe_cnt > 3'd1);
  assign take       = cap_buc | (cap_bcf & cap_carry) | (cap_bbf & cap_borrow);

  assign io_out = out_sel ? pc : r3;

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    out_sel_nxt      = out_sel;
    branch_taken_nxt = 1'b0;
    err_nxt          = err;
    capture          = 1'b0;
    case (state)
      FETCH: begin
        if (load_en) begin
          pc_nxt = load_val;
        end else if (instr_valid) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        if (multi_hot) begin
          // Conflicting strobes: flag it and step over the instruction.
          err_nxt = 1'b1;
          pc_nxt  = pc + 8'd1;
        end else if (take) begin
          pc_nxt           = pc + cap_r3;
          branch_taken_nxt = 1'b1;
        end else begin
          pc_nxt      = pc + 8'd1;
          out_sel_nxt = out_sel ^ cap_tog;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= 8'h00;
      out_sel      <= 1'b0;
      branch_taken <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      out_sel      <= out_sel_nxt;
      branch_taken <= branch_taken_nxt;
      err          <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_bcf    <= 1'b0;
      cap_bbf    <= 1'b0;
      cap_buc    <= 1'b0;
      cap_tog    <= 1'b0;
      cap_carry  <= 1'b0;
      cap_borrow <= 1'b0;
      cap_r3     <= 8'h00;
    end else if (capture) begin
      cap_bcf    <= bcf;
      cap_bbf    <= bbf;
      cap_buc    <= buc;
      cap_tog    <= toggleOut;
      cap_carry  <= carry;
      cap_borrow <= borrow;
      cap_r3     <= r3;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Stimulus tasks push the
//            expected post-edge state into a scoreboard queue; a monitor pops
//            and compares after every reset, load or EXEC edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic       bcf, bbf, buc, toggleOut, carry, borrow;
  logic [7:0] r3;
  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] pc;
  logic       out_sel;
  logic [7:0] io_out;
  logic       branch_taken;
  logic       err;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .bcf          (bcf),
    .bbf          (bbf),
    .buc          (buc),
    .toggleOut    (toggleOut),
    .carry        (carry),
    .borrow       (borrow),
    .r3           (r3),
    .load_en      (load_en),
    .load_val     (load_val),
    .pc           (pc),
    .out_sel      (out_sel),
    .io_out       (io_out),
    .branch_taken (branch_taken),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic       os;
    logic [7:0] io;
    logic       bt;
    logic       err;
    logic       rdy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state of the sequencer
  logic [7:0] m_pc  = 8'h00;
  logic       m_os  = 1'b0;
  logic       m_err = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic push(input string tag, input logic bt, input logic rdy);
    exp_t e;
    e.pc  = m_pc;
    e.os  = m_os;
    e.io  = m_os ? m_pc : r3;
    e.bt  = bt;
    e.err = m_err;
    e.rdy = rdy;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: bench-side tracking of when the DUT produces a new state.
  logic in_exec = 1'b0;
  logic due;
  exp_t got;
  always @(posedge clk) begin
    due     = rst || in_exec || load_en;
    in_exec = !rst && !in_exec && !load_en && instr_valid;
    if (due) begin
      #1;
      if (sb.size() == 0) begin
        cmp("sb_underflow", 8'd1, 8'd0);
      end else begin
        got = sb.pop_front();
        cmp({got.tag, ".pc"},           pc,                    got.pc);
        cmp({got.tag, ".out_sel"},      {7'd0, out_sel},       {7'd0, got.os});
        cmp({got.tag, ".io_out"},       io_out,                got.io);
        cmp({got.tag, ".branch_taken"}, {7'd0, branch_taken},  {7'd0, got.bt});
        cmp({got.tag, ".err"},          {7'd0, err},           {7'd0, got.err});
        cmp({got.tag, ".instr_ready"},  {7'd0, instr_ready},   {7'd0, got.rdy});
      end
    end
  end

  task automatic clear_inputs();
    instr_valid = 1'b0;
    bcf = 1'b0; bbf = 1'b0; buc = 1'b0; toggleOut = 1'b0;
    carry = 1'b0; borrow = 1'b0;
    load_en = 1'b0; load_val = 8'h00;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    m_pc = 8'h00; m_os = 1'b0; m_err = 1'b0;
    for (int i = 0; i < n; i++) push("reset", 1'b0, 1'b0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // External load; with_valid also presents an instruction that must be ignored.
  task automatic do_load(input logic [7:0] val, input logic with_valid);
    @(negedge clk);
    load_en = 1'b1; load_val = val;
    instr_valid = with_valid; buc = with_valid;
    #1 cmp("ready_during_load", {7'd0, instr_ready}, 8'd0);
    m_pc = val;
    push("load", 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic issue(input logic i_cf, input logic i_bf, input logic i_uc,
                       input logic i_tg, input logic cy, input logic bw,
                       input logic [7:0] off, input logic rst_in_exec);
    int  n;
    logic tk;
    logic bt;
    @(negedge clk);
    bcf = i_cf; bbf = i_bf; buc = i_uc; toggleOut = i_tg;
    carry = cy; borrow = bw; r3 = off; instr_valid = 1'b1;
    #1 cmp("ready_in_fetch", {7'd0, instr_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    if (rst_in_exec) begin
      clear_inputs();
      rst = 1'b1;
      m_pc = 8'h00; m_os = 1'b0; m_err = 1'b0;
      push("rst_in_exec", 1'b0, 1'b0);
    end else begin
      n  = int'(i_cf) + int'(i_bf) + int'(i_uc) + int'(i_tg);
      tk = i_uc | (i_cf & cy) | (i_bf & bw);
      bt = 1'b0;
      if (n > 1) begin
        m_err = 1'b1;
        m_pc  = m_pc + 8'd1;
      end else if (tk) begin
        m_pc = m_pc + off;
        bt   = 1'b1;
      end else begin
        m_pc = m_pc + 8'd1;
        if (i_tg) m_os = ~m_os;
      end
      // Live inputs flipped and a load/instruction offered during EXEC:
      // all of it must be ignored.
      bcf = ~i_cf; bbf = ~i_bf; buc = ~i_uc; toggleOut = ~i_tg;
      carry = ~cy; borrow = ~bw;
      instr_valid = 1'b1; load_en = 1'b1; load_val = 8'h5A;
      push("exec", bt, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1 cmp("ready_after_exec", {7'd0, instr_ready}, 8'd1);
  endtask

  initial begin
    rst = 1'b0;
    r3  = 8'h00;
    clear_inputs();

    do_reset(2);

    // Three plain steps from reset
    issue(0, 0, 0, 0, 0, 0, 8'h00, 0);
    issue(0, 0, 0, 0, 0, 0, 8'h00, 0);
    issue(0, 0, 0, 0, 0, 0, 8'h00, 0);

    // Unconditional branch, then untaken carry branch
    do_load(8'h10, 0);
    issue(0, 0, 1, 0, 0, 0, 8'h05, 0);
    do_load(8'h10, 0);
    issue(1, 0, 0, 0, 0, 0, 8'h05, 0);
    // Taken carry branch, untaken borrow branch
    issue(1, 0, 0, 0, 1, 0, 8'h20, 0);
    issue(0, 1, 0, 0, 1, 0, 8'h20, 0);

    // Borrow branch wrapping past 0xFF, then plain step wrap
    do_load(8'hFE, 0);
    issue(0, 1, 0, 0, 0, 1, 8'h03, 0);
    do_load(8'hFF, 0);
    issue(0, 0, 0, 0, 0, 0, 8'h03, 0);

    // Output toggle twice
    do_load(8'h07, 0);
    issue(0, 0, 0, 1, 0, 0, 8'hAA, 0);
    issue(0, 0, 0, 1, 0, 0, 8'hAA, 0);

    // Multi-hot strobe: sticky error, plain step, then reset during EXEC
    issue(1, 0, 1, 0, 1, 0, 8'h40, 0);
    issue(0, 0, 0, 0, 0, 0, 8'h40, 0);
    issue(0, 0, 1, 0, 0, 0, 8'h40, 1);

    // Load and instruction in the same FETCH cycle: load wins
    do_load(8'h33, 1);
    issue(0, 0, 0, 0, 0, 0, 8'h11, 0);

    repeat (3) @(negedge clk);
    cmp("sb_leftover", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
